// File: rtl/imul_int_mul_iter_param.sv
// Iterative shift-add integer multiplier with val/rdy on both sides.
// Signed operands are reduced to magnitudes; the sign is reapplied to the 2N-bit product.
module imul_int_mul_iter_param #(
  parameter int NBITS      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recv_val,
  output logic               recv_rdy,
  input  logic [2*NBITS+1:0] recv_msg,
  output logic               send_val,
  input  logic               send_rdy,
  output logic [NBITS-1:0]   send_msg
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [2*NBITS-1:0] a_sh_q, a_sh_d;
  logic [NBITS-1:0]   b_q, b_d;
  logic [NBITS-1:0]   result_q, result_d;
  logic               neg_q, neg_d;
  logic               high_q, high_d;

  logic               sgn_in;
  logic [NBITS-1:0]   a_in, b_in;
  logic [2*NBITS-1:0] acc_sum, prod;
  logic               last;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_d      = b_q;
    result_d = result_q;
    neg_d    = neg_q;
    high_d   = high_q;

    sgn_in  = recv_msg[2*NBITS+1];
    a_in    = recv_msg[2*NBITS-1:NBITS];
    b_in    = recv_msg[NBITS-1:0];
    acc_sum = b_q[0] ? (acc_q + a_sh_q) : acc_q;
    prod    = neg_q ? -acc_sum : acc_sum;
    // Early exit once no set multiplier bits remain beyond the one consumed this cycle.
    last    = (cnt_q == CW'(NBITS - 1)) || ((EARLY_TERM != 0) && ((b_q >> 1) == '0));

    unique case (state_q)
      IDLE: begin
        if (recv_val) begin
          state_d = CALC;
          a_sh_d  = {{NBITS{1'b0}}, ((sgn_in && a_in[NBITS-1]) ? -a_in : a_in)};
          b_d     = (sgn_in && b_in[NBITS-1]) ? -b_in : b_in;
          neg_d   = sgn_in && (a_in[NBITS-1] ^ b_in[NBITS-1]);
          high_d  = recv_msg[2*NBITS];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      CALC: begin
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << 1;
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          state_d  = DONE;
          result_d = high_q ? prod[2*NBITS-1:NBITS] : prod[NBITS-1:0];
        end
      end
      DONE: begin
        if (send_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    recv_rdy = (state_q == IDLE);
    send_val = (state_q == DONE);
    send_msg = result_q & {NBITS{send_val}};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_q      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      high_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_q      <= b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      high_q   <= high_d;
    end
  end

endmodule

// File: tb/tb_imul_int_mul_iter_param.sv
// Bench for imul_int_mul_iter_param: one early-terminating and one fixed-latency instance,
// both checked every cycle against a transaction-level product/latency model.
module tb_imul_int_mul_iter_param;

  localparam int N = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n    [2];
  logic         recv_val [2];
  logic         recv_rdy [2];
  logic [2*N+1:0] recv_msg [2];
  logic         send_val [2];
  logic         send_rdy [2];
  logic [N-1:0] send_msg [2];

  imul_int_mul_iter_param #(.NBITS(N), .EARLY_TERM(1)) u_et1 (
    .clk(clk), .reset(rst_n[0]), .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]),
    .recv_msg(recv_msg[0]), .send_val(send_val[0]), .send_rdy(send_rdy[0]),
    .send_msg(send_msg[0]));

  imul_int_mul_iter_param #(.NBITS(N), .EARLY_TERM(0)) u_et0 (
    .clk(clk), .reset(rst_n[1]), .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]),
    .recv_msg(recv_msg[1]), .send_val(send_val[1]), .send_rdy(send_rdy[1]),
    .send_msg(send_msg[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // Reference arithmetic: full 64-bit product, then pick a half.
  function automatic logic [31:0] ref_mul(input logic s, input logic h,
                                          input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
    end else begin
      ua = a;
      ub = b;
      p  = ua * ub;
    end
    return h ? p[63:32] : p[31:0];
  endfunction

  function automatic int ref_k(input bit et, input logic s, input logic [31:0] b);
    logic [31:0] m;
    int          k;
    if (!et) return 32;
    m = (s && b[31]) ? -b : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0:       r = 32'h0;
      1:       r = 32'h8000_0000;
      2:       r = 32'hFFFF_FFFF;
      default: r = $urandom >> $urandom_range(0, 31);
    endcase
    return r;
  endfunction

  // Transaction model: 0 = waiting for request, 1 = computing, 2 = holding a response.
  int          m_phase [2] = '{0, 0};
  int          m_wait  [2] = '{0, 0};
  logic [31:0] m_exp   [2] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        m_phase[d] = 0;
      end else if (m_phase[d] == 0) begin
        if (recv_val[d]) begin
          m_exp[d]   = ref_mul(recv_msg[d][65], recv_msg[d][64], recv_msg[d][63:32], recv_msg[d][31:0]);
          m_wait[d]  = ref_k(d == 0, recv_msg[d][65], recv_msg[d][31:0]);
          m_phase[d] = 1;
        end
      end else if (m_phase[d] == 1) begin
        m_wait[d]--;
        if (m_wait[d] == 0) m_phase[d] = 2;
      end else begin
        if (send_rdy[d]) m_phase[d] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("mon_recv_rdy", d, recv_rdy[d], m_phase[d] == 0);
        chk("mon_send_val", d, send_val[d], m_phase[d] == 2);
        chk("mon_send_msg", d, send_msg[d], (m_phase[d] == 2) ? m_exp[d] : 32'h0);
      end
    end
  end

  // All input changes happen 2 time units after a rising edge; tasks start and end there.
  task automatic send_req(input int d, input logic s, input logic h,
                          input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    recv_msg[d] = {s, h, a, b};
    recv_val[d] = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (recv_rdy[d]) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #2;
    recv_val[d] = 1'b0;
    recv_msg[d] = {2'($urandom), $urandom, $urandom};
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d actual=no_accept expected=accept", d);
    end
  endtask

  task automatic wait_resp(input int d, output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (send_val[d]) break;
    end
  endtask

  task automatic run_txn(input string name, input int d, input logic s, input logic h,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int k);
    int lat;
    send_req(d, s, h, a, b);
    wait_resp(d, lat);
    chk({name, "_msg"}, d, send_msg[d], exp);
    chk({name, "_lat"}, d, lat, k + 1);
    @(posedge clk); #2;
    @(negedge clk);
    chk({name, "_rdy_back"}, d, recv_rdy[d], 1'b1);
    @(posedge clk); #2;
  endtask

  task automatic rand_stream(input int d, input int n);
    bit done;
    bit ok;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          recv_msg[d] = {1'($urandom), 1'($urandom), rnd_op(), rnd_op()};
          recv_val[d] = 1'b1;
          ok = 1'b0;
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (recv_rdy[d]) begin
              ok = 1'b1;
              break;
            end
          end
          if (!ok) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout dut%0d actual=no_accept expected=accept", d);
            break;
          end
          @(posedge clk); #2;
        end
        recv_val[d] = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          if (!done) send_rdy[d] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    send_rdy[d] = 1'b1;
    repeat (40) @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse(input int d);
    rst_n[d] = 1'b0;
    @(posedge clk); #2;
    rst_n[d] = 1'b1;
  endtask

  typedef struct {
    logic        s;
    logic        h;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          k0;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 3};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32};
    vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32};
    vecs[6] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32};
    vecs[7] = '{1'b1, 1'b1, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};
    vecs[8] = '{1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1};
    vecs[9] = '{1'b1, 1'b1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1};

    for (int d = 0; d < 2; d++) begin
      rst_n[d]    = 1'b0;
      recv_val[d] = 1'b0;
      recv_msg[d] = '0;
      send_rdy[d] = 1'b1;
    end

    for (int i = 0; i < 10; i++) begin
      chk("model_mul", i, ref_mul(vecs[i].s, vecs[i].h, vecs[i].a, vecs[i].b), vecs[i].exp);
      chk("model_k", i, ref_k(1'b1, vecs[i].s, vecs[i].b), vecs[i].k0);
    end

    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_recv_rdy", d, recv_rdy[d], 1'b1);
      chk("reset_send_val", d, send_val[d], 1'b0);
      chk("reset_send_msg", d, send_msg[d], 32'h0);
    end
    @(posedge clk); #2;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 10; i++)
        run_txn($sformatf("vec%0d", i), d, vecs[i].s, vecs[i].h, vecs[i].a, vecs[i].b,
                vecs[i].exp, (d == 0) ? vecs[i].k0 : 32);

    // Backpressure: response held while a new request waits at the input.
    send_rdy[0] = 1'b0;
    send_req(0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_0010);
    wait_resp(0, lat);
    chk("bp_first_lat", 0, lat, 6);
    @(posedge clk); #2;
    recv_msg[0] = {1'b0, 1'b0, 32'h0000_0007, 32'h0000_0009};
    recv_val[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_msg", 0, send_msg[0], 32'h0001_2340);
      chk("bp_hold_val", 0, send_val[0], 1'b1);
      chk("bp_hold_rdy", 0, recv_rdy[0], 1'b0);
    end
    @(posedge clk); #2;
    send_rdy[0] = 1'b1;
    @(negedge clk);
    chk("bp_last_done_val", 0, send_val[0], 1'b1);
    chk("bp_last_done_rdy", 0, recv_rdy[0], 1'b0);
    @(negedge clk);
    chk("bp_idle_rdy", 0, recv_rdy[0], 1'b1);
    chk("bp_idle_val", 0, send_val[0], 1'b0);
    @(posedge clk); #2;
    recv_val[0] = 1'b0;
    wait_resp(0, lat);
    chk("bp_second_msg", 0, send_msg[0], 32'h0000_003F);
    chk("bp_second_lat", 0, lat, 5);
    @(posedge clk); #2;

    // Synchronous reset mid-computation and mid-response, then a clean transaction.
    for (int d = 0; d < 2; d++) begin
      send_req(d, 1'b0, 1'b0, 32'h0000_FFFF, 32'h0000_FFFF);
      @(posedge clk); #2;
      reset_pulse(d);
      @(negedge clk);
      chk("rst_calc_recv_rdy", d, recv_rdy[d], 1'b1);
      chk("rst_calc_send_val", d, send_val[d], 1'b0);
      chk("rst_calc_send_msg", d, send_msg[d], 32'h0);
      @(posedge clk); #2;

      send_rdy[d] = 1'b0;
      send_req(d, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003);
      wait_resp(d, lat);
      chk("rst_done_reached", d, send_val[d], 1'b1);
      @(posedge clk); #2;
      reset_pulse(d);
      send_rdy[d] = 1'b1;
      @(negedge clk);
      chk("rst_done_recv_rdy", d, recv_rdy[d], 1'b1);
      chk("rst_done_send_val", d, send_val[d], 1'b0);
      chk("rst_done_send_msg", d, send_msg[d], 32'h0);
      @(posedge clk); #2;
      run_txn("post_rst_7x6", d, 1'b0, 1'b0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A,
              (d == 0) ? 3 : 32);
    end

    rand_stream(0, 1000);
    rand_stream(1, 200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
